// File: rtl/ctr_stream_if.sv
// Pixel stream bundle between the fractal core, this output buffer and the host.
// The slave side is the buffer; the master side is whatever feeds it counts and acks pixels.
interface ctr_stream_if #(
    parameter int CTRWIDTH = 7
);
    logic [CTRWIDTH-1:0] ctr_in;
    logic                ctr_valid;
    logic                stall;
    logic                ack_tgl;
    logic                pix_valid;
    logic [3:0]          pix_out;
    logic                in_set;
    logic                line_end;
    logic                frame_end;

    modport master (
        output ctr_in, ctr_valid, ack_tgl,
        input  stall, pix_valid, pix_out, in_set, line_end, frame_end
    );

    modport slave (
        input  ctr_in, ctr_valid, ack_tgl,
        output stall, pix_valid, pix_out, in_set, line_end, frame_end
    );
endinterface

// File: rtl/ctr_stream_out.sv
// Buffers finished iteration counts, tags them with line/frame position and
// hands them to a host that acknowledges each pixel by toggling ack_tgl.
module ctr_stream_out #(
    parameter int CTRWIDTH = 7,
    parameter int DEPTH    = 4,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 48
) (
    input  logic                clk,
    input  logic                reset,
    ctr_stream_if.slave         bus,
    input  logic [CTRWIDTH-1:0] max_ctr,
    input  logic [1:0]          shift,
    input  logic                clear,
    output logic                overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int EW = CTRWIDTH + 2;

    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          ovf_q, ovf_d;
    logic          a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic                  pop_req, empty, full, pop, wr;
    logic                  line_flag, frame_flag;
    logic [EW-1:0]         head;
    logic [CTRWIDTH-1:0]   head_ctr;
    logic [CTRWIDTH+2:0]   head_ext;

    always_comb begin
        pop_req    = a2_q ^ a3_q;
        empty      = (cnt_q == '0);
        full       = (cnt_q == (AW+1)'(DEPTH));
        pop        = pop_req && !empty && !clear;
        // A full buffer still takes a strobe when a slot frees up on the same edge.
        wr         = bus.ctr_valid && (!full || pop) && !clear;
        line_flag  = (x_q == XW'(IMG_W - 1));
        frame_flag = line_flag && (y_q == YW'(IMG_H - 1));
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        x_d      = x_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        a1_d     = bus.ack_tgl;
        a2_d     = a1_q;
        a3_d     = a2_q;
        if (clear) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            x_d      = '0;
            y_d      = '0;
            ovf_d    = 1'b0;
        end else begin
            cnt_d = cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
            if (wr) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (line_flag) begin
                    x_d = '0;
                    y_d = frame_flag ? '0 : y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (bus.ctr_valid && full && !pop)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            a1_q     <= 1'b0;
            a2_q     <= 1'b0;
            a3_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            a3_q     <= a3_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (wr) begin
            mem_q[wr_ptr_q] <= {bus.ctr_in, line_flag, frame_flag};
        end
    end

    // Nibble select and set test follow live max_ctr/shift, not values at write time.
    always_comb begin
        head          = mem_q[rd_ptr_q];
        head_ctr      = head[EW-1:2];
        head_ext      = {3'b000, head_ctr};
        bus.stall     = full;
        bus.pix_valid = !empty;
        bus.pix_out   = empty ? 4'h0 : head_ext[shift +: 4];
        bus.in_set    = !empty && (head_ctr >= max_ctr);
        bus.line_end  = !empty && head[1];
        bus.frame_end = !empty && head[0];
        overflow      = ovf_q;
    end
endmodule

// File: tb/tb_ctr_stream_out.sv
module tb_ctr_stream_out;
    localparam int CW    = 7;
    localparam int DEPTH = 4;
    localparam int IW    = 4;
    localparam int IH    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] max_ctr;
    logic [1:0]    shift;
    logic          clear;
    logic          overflow;

    ctr_stream_if #(.CTRWIDTH(CW)) bus ();

    ctr_stream_out #(.CTRWIDTH(CW), .DEPTH(DEPTH), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .max_ctr  (max_ctr),
        .shift    (shift),
        .clear    (clear),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ctr;
        logic          line;
        logic          frame;
    } ent_t;

    ent_t sb[$];
    int   m_x, m_y;
    int   checks, errors;

    function automatic logic [7:0] model(ent_t e);
        logic [CW+2:0] t;
        t = {3'b000, e.ctr} >> shift;
        return {1'b1, t[3:0], (e.ctr >= max_ctr), e.line, e.frame};
    endfunction

    function automatic logic [7:0] observed();
        return {bus.pix_valid, bus.pix_out, bus.in_set, bus.line_end, bus.frame_end};
    endfunction

    function automatic ent_t tag(input logic [CW-1:0] c);
        ent_t e;
        e.ctr   = c;
        e.line  = (m_x == IW - 1);
        e.frame = (m_x == IW - 1) && (m_y == IH - 1);
        if (m_x == IW - 1) begin
            m_x = 0;
            m_y = (m_y == IH - 1) ? 0 : m_y + 1;
        end else begin
            m_x = m_x + 1;
        end
        return e;
    endfunction

    task automatic strobe(input logic [CW-1:0] c);
        @(negedge clk);
        bus.ctr_in    = c;
        bus.ctr_valid = 1'b1;
        if (sb.size() < DEPTH)
            sb.push_back(tag(c));
        @(negedge clk);
        bus.ctr_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        bus.ack_tgl = ~bus.ack_tgl;
        repeat (3) @(negedge clk);
        if (sb.size() > 0)
            void'(sb.pop_front());
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sb.delete();
        m_x = 0;
        m_y = 0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.ack_tgl   = 1'b1;
        bus.ctr_valid = 1'b0;
        bus.ctr_in    = '0;
        clear         = 1'b0;
        max_ctr       = 7'd127;
        shift         = 2'd0;
        m_x = 0;
        m_y = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({observed(), bus.stall, overflow} !== 10'h0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", {observed(), bus.stall, overflow});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({observed(), bus.stall, overflow} !== 10'h0) begin
            errors++;
            $display("FAIL reset_release got=%h exp=0", {observed(), bus.stall, overflow});
        end
    endtask

    task automatic test_basic();
        strobe(7'd5);
        strobe(7'd9);
        strobe(7'd127);
        checks++;
        if ({bus.pix_valid, bus.pix_out, bus.in_set} !== 6'b1_0101_0) begin
            errors++;
            $display("FAIL basic_first got=%b exp=1_0101_0", {bus.pix_valid, bus.pix_out, bus.in_set});
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                checks++;
                if ({bus.pix_valid, bus.pix_out, bus.in_set} !== 6'b1_1111_1) begin
                    errors++;
                    $display("FAIL basic_in_set got=%b exp=1_1111_1", {bus.pix_valid, bus.pix_out, bus.in_set});
                end
            end
            checks++;
            if (observed() !== model(sb[0])) begin
                errors++;
                $display("FAIL basic_head%0d got=%h exp=%h", i, observed(), model(sb[0]));
            end
            ack();
        end
        checks++;
        if (observed() !== 8'h0) begin
            errors++;
            $display("FAIL basic_empty got=%h exp=0", observed());
        end
    endtask

    task automatic test_shift();
        shift = 2'd2;
        strobe(7'b1011010);
        checks++;
        if (bus.pix_out !== 4'b0110) begin
            errors++;
            $display("FAIL shift2 got=%b exp=0110", bus.pix_out);
        end
        shift = 2'd1;
        @(negedge clk);
        checks++;
        if (bus.pix_out !== 4'b1101) begin
            errors++;
            $display("FAIL shift1 got=%b exp=1101", bus.pix_out);
        end
        shift = 2'd3;
        @(negedge clk);
        checks++;
        if (observed() !== model(sb[0]) || bus.pix_out !== 4'b1011) begin
            errors++;
            $display("FAIL shift3 got=%h exp=%h", observed(), model(sb[0]));
        end
        shift = 2'd0;
        ack();
    endtask

    task automatic test_overflow();
        do_clear();
        checks++;
        if ({observed(), overflow} !== 9'h0) begin
            errors++;
            $display("FAIL clear_state got=%h exp=0", {observed(), overflow});
        end
        for (int i = 1; i <= 4; i++)
            strobe(7'(i * 10));
        checks++;
        if ({bus.stall, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL full_stall got=%b exp=10", {bus.stall, overflow});
        end
        strobe(7'd50);
        checks++;
        if ({bus.stall, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL overflow_set got=%b exp=11", {bus.stall, overflow});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (observed() !== model(sb[0])) begin
                errors++;
                $display("FAIL ovf_drain%0d got=%h exp=%h", i, observed(), model(sb[0]));
            end
            ack();
        end
        checks++;
        if ({observed(), bus.stall, overflow} !== 10'b1) begin
            errors++;
            $display("FAIL fifth_absent got=%h exp=1", {observed(), bus.stall, overflow});
        end
        do_clear();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_frame();
        do_clear();
        for (int i = 0; i < 9; i++) begin
            strobe(7'((i * 13) % 128));
            checks++;
            if ({bus.line_end, bus.frame_end} !== {(i % 4) == 3, i == 7}) begin
                errors++;
                $display("FAIL frame_flags%0d got=%b exp=%b", i, {bus.line_end, bus.frame_end}, {(i % 4) == 3, i == 7});
            end
            checks++;
            if (observed() !== model(sb[0])) begin
                errors++;
                $display("FAIL frame_head%0d got=%h exp=%h", i, observed(), model(sb[0]));
            end
            ack();
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int i = 0; i < 4; i++)
            strobe(7'(100 + i));
        @(negedge clk);
        bus.ack_tgl = ~bus.ack_tgl;
        repeat (2) @(negedge clk);
        bus.ctr_in    = 7'd77;
        bus.ctr_valid = 1'b1;
        @(negedge clk);
        bus.ctr_valid = 1'b0;
        void'(sb.pop_front());
        sb.push_back(tag(7'd77));
        checks++;
        if ({bus.stall, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_stall got=%b exp=10", {bus.stall, overflow});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (observed() !== model(sb[0])) begin
                errors++;
                $display("FAIL b2b_drain%0d got=%h exp=%h", i, observed(), model(sb[0]));
            end
            ack();
        end
        checks++;
        if (observed() !== 8'h0) begin
            errors++;
            $display("FAIL b2b_empty got=%h exp=0", observed());
        end
    endtask

    task automatic test_ack_timing();
        do_clear();
        strobe(7'd11);
        strobe(7'd22);
        @(negedge clk);
        bus.ack_tgl = ~bus.ack_tgl;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== model(sb[0])) begin
            errors++;
            $display("FAIL ack_early got=%h exp=%h", observed(), model(sb[0]));
        end
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== model(sb[1])) begin
            errors++;
            $display("FAIL ack_edge got=%h exp=%h", observed(), model(sb[1]));
        end
        void'(sb.pop_front());
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({observed(), bus.stall, overflow} !== 10'h0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", {observed(), bus.stall, overflow});
        end
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_x = 0;
        m_y = 0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++)
            strobe(7'(60 + i));
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (observed() !== model(sb[0])) begin
                errors++;
                $display("FAIL post_reset%0d got=%h exp=%h", i, observed(), model(sb[0]));
            end
            ack();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_shift();
        test_overflow();
        test_frame();
        test_back_to_back();
        test_ack_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctr_stream_out.md
CTR_STREAM_OUT -- requirements
Module: ctr_stream_out

Interface
REQ-001 Parameter CTRWIDTH, default 7: width of iteration count from mandelbrot core.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, >=2.
REQ-003 Parameter IMG_W, default 64: pixels per line.
REQ-004 Parameter IMG_H, default 48: lines per frame.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 ctr_in  input  CTRWIDTH  iteration count of finished pixel.
REQ-008 ctr_valid  input  1  single-cycle strobe, ctr_in valid (core's new_ctr).
REQ-009 max_ctr  input  CTRWIDTH  iteration limit; count >= max_ctr means point in set.
REQ-010 shift  input  2  nibble select: pix_out = ctr[3+shift:shift].
REQ-011 clear  input  1  synchronous flush.
REQ-012 ack_tgl  input  1  host acknowledge, asynchronous toggle; each edge consumes one pixel.
REQ-013 stall  output  1  FIFO full; core must hold off.
REQ-014 pix_valid  output  1  FIFO non-empty; pix_out/flags valid.
REQ-015 pix_out  output  4  selected nibble of head entry.
REQ-016 in_set  output  1  head entry count >= max_ctr.
REQ-017 line_end  output  1  head entry is last pixel of a line.
REQ-018 frame_end  output  1  head entry is last pixel of frame.
REQ-019 overflow  output  1  sticky: a strobe was dropped.

Function
REQ-020 Entry stores {ctr_in, line_end flag, frame_end flag}; in_set and pix_out computed combinationally from head entry and current max_ctr/shift.
REQ-021 Pixel counters x (0..IMG_W-1), y (0..IMG_H-1) tagged onto each written entry; line flag = (x==IMG_W-1); frame flag = line flag and (y==IMG_H-1).
REQ-022 Write accepted when ctr_valid and (not full or pop in same cycle); accepted write advances x; x wraps to 0 and y increments at IMG_W-1; y wraps to 0 at IMG_H-1.
REQ-023 ctr_valid while full without same-cycle pop: data dropped, counters not advanced, overflow set to 1 next edge, held until clear/reset.
REQ-024 ack_tgl passes through 2-flop synchroniser a1->a2 plus history flop a3; pop request = a2 xor a3.
REQ-025 Toggle change settling before edge N: a1 at N, a2 at N+1, pop at edge N+2; outputs show next entry after edge N+2.
REQ-026 Pop request with FIFO empty: ignored, no state change except a3 update.
REQ-027 Simultaneous write and pop: occupancy unchanged; full FIFO accepts write; empty FIFO with write+pop request: write accepted, pop ignored.
REQ-028 stall = (occupancy == DEPTH); pix_valid = (occupancy != 0); both combinational from registered occupancy.
REQ-029 clear: next edge empties FIFO, x=y=0, overflow=0; concurrent ctr_valid dropped without setting overflow; synchroniser flops unaffected.
REQ-030 Read/write pointers wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.
REQ-031 When pix_valid=0, pix_out, in_set, line_end, frame_end driven 0.

Reset
REQ-032 reset asserted: occupancy=0, pointers=0, x=y=0, overflow=0, a1=a2=a3=0; hence stall=0, pix_valid=0, all data outputs 0.
REQ-033 reset mid-operation discards buffered pixels; first strobe after release is pixel (0,0).
REQ-034 ack_tgl held 1 through reset release yields exactly one spurious pop request, ignored as FIFO empty.

Verification
REQ-035 Write ctr 5,9,127 (max_ctr=127, shift=0) -> pix_valid=1, pix_out=5, in_set=0; after two acks head=127, pix_out=F, in_set=1.
REQ-036 shift=2, ctr_in=7'b1011010 -> pix_out=4'b0110.
REQ-037 Five strobes, no ack, DEPTH=4 -> stall=1 after 4th, overflow=1 after 5th; acks return 4 entries in order, 5th absent.
REQ-038 IMG_W=4, IMG_H=2, 8 strobes with interleaved acks -> line_end on pixels 3 and 7, frame_end only on 7; 9th tagged (0,0).
REQ-039 Full FIFO, ctr_valid coincident with pop edge -> write accepted, stall stays 1, overflow stays 0.
REQ-040 ack_tgl flipped at cycle 10 -> head changes after edge 12, not 11; reset pulse mid-stream -> all outputs 0 asynchronously.
